// File: rtl/point8_ifft_pkg.sv
// Shared constants, FSM state type and helpers for point8_ifft.
// Exports TW_C/TW_FRAC twiddle scaling, state_t, bitrev3(), sat().
package point8_ifft_pkg;

    localparam int TW_C    = 181;
    localparam int TW_FRAC = 8;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Clamp v into the signed (n+1)-bit range.
    function automatic int sat(input int v, input int n);
        int hi;
        int lo;
        hi = (1 << n) - 1;
        lo = -(1 << n);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 inverse butterfly with 1/2 scaling.
// In: a, b (IW-bit complex), k (twiddle index). Out: y0=(a+bW)/2, y1=(a-bW)/2.
module ifft_butterfly
    import point8_ifft_pkg::*;
#(
    parameter int IW = 11
) (
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    input  logic        [1:0]    k,
    output logic signed [IW-1:0] y0_re,
    output logic signed [IW-1:0] y0_im,
    output logic signed [IW-1:0] y1_re,
    output logic signed [IW-1:0] y1_im
);

    // Wide enough for an IW-bit operand times TW_C plus a sum.
    localparam int W = IW + 10;

    logic signed [W-1:0] ar;
    logic signed [W-1:0] ai;
    logic signed [W-1:0] br;
    logic signed [W-1:0] bi;
    logic signed [W-1:0] c;
    logic signed [W-1:0] tr;
    logic signed [W-1:0] ti;

    assign ar = W'(a_re);
    assign ai = W'(a_im);
    assign br = W'(b_re);
    assign bi = W'(b_im);
    assign c  = W'(TW_C);

    // W8^-k: k0=1, k1=C+jC, k2=j (exact), k3=-C+jC.
    always_comb begin
        tr = br;
        ti = bi;
        unique case (k)
            2'd0: begin
                tr = br;
                ti = bi;
            end
            2'd1: begin
                tr = (br * c - bi * c) >>> TW_FRAC;
                ti = (br * c + bi * c) >>> TW_FRAC;
            end
            2'd2: begin
                tr = -bi;
                ti = br;
            end
            2'd3: begin
                tr = (-(br * c) - bi * c) >>> TW_FRAC;
                ti = (br * c - bi * c) >>> TW_FRAC;
            end
        endcase
    end

    assign y0_re = IW'((ar + tr) >>> 1);
    assign y0_im = IW'((ai + ti) >>> 1);
    assign y1_re = IW'((ar - tr) >>> 1);
    assign y1_im = IW'((ai - ti) >>> 1);

endmodule

// File: rtl/point8_ifft.sv
// Sequential 8-point radix-2 DIT inverse FFT with built-in 1/8 scaling.
// Ports: clk, rst; in_valid/in_ready/in_re/in_im (bins k=0..7);
// out_valid/out_ready/out_re/out_im/out_last (samples n=0..7); busy.
module point8_ifft
    import point8_ifft_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = N + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N:0]   in_re,
    input  logic signed [N:0]   in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N:0]   out_re,
    output logic signed [N:0]   out_im,
    output logic                out_last,
    output logic                busy
);

    state_t              state;
    logic [2:0]          cnt;
    logic [1:0]          stage;
    logic [1:0]          bfly;
    logic [2:0]          top;
    logic [2:0]          bot;
    logic [1:0]          tw;
    logic signed [IW-1:0] bank_re [8];
    logic signed [IW-1:0] bank_im [8];
    logic signed [IW-1:0] y0_re;
    logic signed [IW-1:0] y0_im;
    logic signed [IW-1:0] y1_re;
    logic signed [IW-1:0] y1_im;

    // Butterfly addressing per stage: span 1, 2, 4.
    always_comb begin
        top = '0;
        bot = '0;
        tw  = '0;
        unique case (stage)
            2'd0: begin
                top = {bfly, 1'b0};
                bot = {bfly, 1'b1};
                tw  = 2'd0;
            end
            2'd1: begin
                top = {bfly[1], 1'b0, bfly[0]};
                bot = {bfly[1], 1'b1, bfly[0]};
                tw  = {bfly[0], 1'b0};
            end
            default: begin
                top = {1'b0, bfly};
                bot = {1'b1, bfly};
                tw  = bfly;
            end
        endcase
    end

    ifft_butterfly #(.IW(IW)) u_bfly (
        .a_re  (bank_re[top]),
        .a_im  (bank_im[top]),
        .b_re  (bank_re[bot]),
        .b_im  (bank_im[bot]),
        .k     (tw),
        .y0_re (y0_re),
        .y0_im (y0_im),
        .y1_re (y1_re),
        .y1_im (y1_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            stage <= '0;
            bfly  <= '0;
            for (int i = 0; i < 8; i++) begin
                bank_re[i] <= '0;
                bank_im[i] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        bank_re[bitrev3(cnt)] <= IW'(in_re);
                        bank_im[bitrev3(cnt)] <= IW'(in_im);
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    bank_re[top] <= y0_re;
                    bank_im[top] <= y0_im;
                    bank_re[bot] <= y1_re;
                    bank_im[bot] <= y1_im;
                    bfly <= bfly + 2'd1;
                    if (bfly == 2'd3) begin
                        if (stage == 2'd2) begin
                            stage <= '0;
                            state <= UNLOAD;
                        end else begin
                            stage <= stage + 2'd1;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == UNLOAD);
    assign busy      = (state != LOAD);
    assign out_last  = out_valid && (cnt == 3'd7);

    always_comb begin
        out_re = '0;
        out_im = '0;
        if (out_valid) begin
            out_re = (N + 1)'(sat(int'(bank_re[cnt]), N));
            out_im = (N + 1)'(sat(int'(bank_im[cnt]), N));
        end
    end

endmodule

// File: tb/tb_point8_ifft.sv
// Self-checking bench for point8_ifft: behavioural IFFT model,
// per-sample scoreboard, latency/backpressure/reset/round-trip checks.
module tb_point8_ifft;

    localparam int N = 8;

    typedef int arr8_t [8];
    typedef struct {
        int re;
        int im;
        bit last;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [N:0] in_re = '0;
    logic signed [N:0] in_im = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [N:0] out_re;
    logic signed [N:0] out_im;
    logic out_last;
    logic busy;

    int checks = 0;
    int errors = 0;
    smp_t exp_q[$];
    int cap_re[$];
    int cap_im[$];
    time last_hs_time = 0;
    time gap_snap = 0;

    point8_ifft #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inverse DFT via radix-2 DIT with the scaled/floored arithmetic.
    task automatic model(input arr8_t xr, input arr8_t xi,
                         output arr8_t yr, output arr8_t yi);
        int br[8];
        int bi[8];
        int wr[4];
        int wi[4];
        int span, tp, bt, k, tr, ti, ar, ai;
        wr = '{256, 181, 0, -181};
        wi = '{0, 181, 256, 181};
        for (int i = 0; i < 8; i++) begin
            int r;
            r = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            br[r] = xr[i];
            bi[r] = xi[i];
        end
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                span = 1 << s;
                tp = ((b >> s) << (s + 1)) + (b & (span - 1));
                bt = tp + span;
                k = (b & (span - 1)) << (2 - s);
                tr = (br[bt] * wr[k] - bi[bt] * wi[k]) >>> 8;
                ti = (br[bt] * wi[k] + bi[bt] * wr[k]) >>> 8;
                ar = br[tp];
                ai = bi[tp];
                br[tp] = (ar + tr) >>> 1;
                bi[tp] = (ai + ti) >>> 1;
                br[bt] = (ar - tr) >>> 1;
                bi[bt] = (ai - ti) >>> 1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            yr[i] = br[i] > 255 ? 255 : (br[i] < -256 ? -256 : br[i]);
            yi[i] = bi[i] > 255 ? 255 : (bi[i] < -256 ? -256 : bi[i]);
        end
    endtask

    // Scoreboard: every output handshake must match the next expected sample.
    always @(negedge clk) begin
        smp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d,%0d, expected none",
                         out_re, out_im);
            end else begin
                e = exp_q.pop_front();
                chk("out_re", int'(out_re), e.re);
                chk("out_im", int'(out_im), e.im);
                chk("out_last", int'(out_last), int'(e.last));
                cap_re.push_back(int'(out_re));
                cap_im.push_back(int'(out_im));
                if (out_last) last_hs_time = $time + 5;
            end
        end
    end

    task automatic send_bin(input int re, input int im, output time t);
        int guard;
        bit r;
        guard = 0;
        in_valid = 1'b1;
        in_re = (N + 1)'(re);
        in_im = (N + 1)'(im);
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            t = $time;
            if (r) break;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0, expected 1");
                break;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input arr8_t xr, input arr8_t xi,
                              input bit keep, input bit gaps,
                              output time t_last);
        arr8_t yr, yi;
        smp_t s;
        time t;
        if (keep) begin
            model(xr, xi, yr, yi);
            for (int n = 0; n < 8; n++) begin
                s.re = yr[n];
                s.im = yi[n];
                s.last = (n == 7);
                exp_q.push_back(s);
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_bin(xr[k], xi[k], t);
            if (k == 0) gap_snap = t - last_hs_time;
        end
        t_last = t;
    endtask

    task automatic drain(input bit rand_ready);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arr8_t xr, xi, yr, yi, er, ei, fr;
        time t1;
        int g, sa, sb, base;
        real ang, sr, si;

        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arr8_t xr, xi, yr, yi, er, ei, fr;
        time t1;
        int g, sa, sb, base, d;
        real ang, sr, si;

        // Pin the model with hand-derived results.
        xr = '{64, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        model(xr, xi, yr, yi);
        for (int n = 0; n < 8; n++) begin
            chk("model_impulse_re", yr[n], 8);
            chk("model_impulse_im", yi[n], 0);
        end
        xr = '{8, 8, 8, 8, 8, 8, 8, 8};
        model(xr, xi, yr, yi);
        er = '{8, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 8; n++) begin
            chk("model_const_re", yr[n], er[n]);
            chk("model_const_im", yi[n], 0);
        end
        xr = '{0, 0, 64, 0, 0, 0, 0, 0};
        model(xr, xi, yr, yi);
        er = '{8, 0, -8, 0, 8, 0, -8, 0};
        ei = '{0, 8, 0, -8, 0, 8, 0, -8};
        for (int n = 0; n < 8; n++) begin
            chk("model_bin2_re", yr[n], er[n]);
            chk("model_bin2_im", yi[n], ei[n]);
        end

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_out_im", int'(out_im), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Impulse with latency check.
        xr = '{64, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 1'b1, 1'b0, t1);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 40);
        chk("latency_ns", int'($time - t1), 125);
        drain(1'b0);

        // Constant.
        xr = '{8, 8, 8, 8, 8, 8, 8, 8};
        send_frame(xr, xi, 1'b1, 1'b0, t1);
        drain(1'b0);

        // Single bin k=2.
        xr = '{0, 0, 64, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 1'b1, 1'b1, t1);
        drain(1'b0);

        // Backpressure after sample 2.
        for (int k = 0; k < 8; k++) begin
            xr[k] = int'($urandom_range(0, 200)) - 100;
            xi[k] = int'($urandom_range(0, 200)) - 100;
        end
        send_frame(xr, xi, 1'b1, 1'b0, t1);
        g = 0;
        while (exp_q.size() > 5 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        out_ready = 1'b0;
        chk("bp_reached", exp_q.size(), 5);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_re", int'(out_re), exp_q[0].re);
            chk("bp_out_im", int'(out_im), exp_q[0].im);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(1'b0);

        // Reset at compute cycle 6, then a clean impulse frame.
        xr = '{64, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 1'b0, 1'b0, t1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        send_frame(xr, xi, 1'b1, 1'b0, t1);
        drain(1'b0);

        // Random frames with input gaps and random out_ready.
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'($urandom_range(0, 511)) - 256;
                xi[k] = int'($urandom_range(0, 511)) - 256;
            end
            send_frame(xr, xi, 1'b1, 1'b1, t1);
            drain(1'b1);
        end

        // Round trip, two frames back to back.
        fr = '{1, -2, 3, -4, 5, -6, 7, -8};
        sa = int'($urandom_range(1, 7));
        sb = int'($urandom_range(1, 7));
        base = cap_re.size();
        for (int fidx = 0; fidx < 2; fidx++) begin
            d = (fidx == 0) ? sa : sb;
            for (int k = 0; k < 8; k++) begin
                sr = 0.0;
                si = 0.0;
                for (int n = 0; n < 8; n++) begin
                    ang = -2.0 * 3.14159265358979 * k * n / 8.0;
                    sr += fr[n] * d * $cos(ang);
                    si += fr[n] * d * $sin(ang);
                end
                xr[k] = int'(sr);
                xi[k] = int'(si);
            end
            send_frame(xr, xi, 1'b1, 1'b0, t1);
            if (fidx == 1) chk("b2b_gap_ns", int'(gap_snap), 10);
        end
        drain(1'b0);
        chk("rt_count", cap_re.size() - base, 16);
        if (cap_re.size() - base == 16) begin
            for (int i = 0; i < 16; i++) begin
                d = (i < 8) ? sa : sb;
                g = cap_re[base + i] - fr[i % 8] * d;
                chk("rt_re_within_tol", int'(g >= -2 && g <= 2), 1);
                g = cap_im[base + i];
                chk("rt_im_within_tol", int'(g >= -2 && g <= 2), 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
